// File: rtl/saturn_bus_program_sequencer.sv
// saturn_bus_program_sequencer: buffers a nibble program, replays it on phase-1 strobes, optional readback (SATURN_BUSPROG_READBACK_EN).
module saturn_bus_program_sequencer (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [3:0] i_phases,
  input  logic [4:0] i_program_address,
  input  logic [4:0] i_program_data,
  input  logic       i_no_read,
  input  logic [3:0] i_bus_nibble,
  output logic       o_bus_busy,
  output logic [3:0] o_bus_nibble,
  output logic       o_bus_cmd,
  output logic       o_bus_strobe,
  output logic [3:0] o_nibble,
  output logic       o_nibble_valid,
  output logic       o_error
);
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, EXEC = 2'd2, READ = 2'd3;
  logic [4:0] r_buf [0:30];
  logic [4:0] r_wp, r_rp, r_last;
  logic [1:0] r_state, w_next;
  logic       w_wr, w_ok, w_done, w_fire;
  assign w_wr   = i_program_address != r_last && i_program_address != 5'd31;
  assign w_ok   = w_wr && i_program_address == r_wp && r_wp != 5'd31 && r_state != EXEC;
  assign w_done = r_state == EXEC && r_rp == r_wp;
  assign w_fire = r_state == EXEC && !w_done && i_phases[1];
  always_comb begin
    w_next = r_state == IDLE ? (w_ok ? LOAD : IDLE) :
             r_state == LOAD ? (w_wr ? LOAD : EXEC) :
             r_state == EXEC ? (w_done ? READ : EXEC) :
                               (w_ok ? LOAD : READ);
  end
  // Buffer contents survive reset.
  always_ff @(posedge i_clk)
    if (i_reset && w_ok) r_buf[r_wp] <= i_program_data;
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state      <= IDLE;
      r_wp         <= '0;
      r_rp         <= '0;
      r_last       <= 5'd31;
      o_bus_busy   <= 1'b0;
      o_bus_nibble <= '0;
      o_bus_cmd    <= 1'b0;
      o_bus_strobe <= 1'b0;
      o_error      <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_last       <= i_program_address;
      r_wp         <= w_done ? 5'd0 : w_ok ? r_wp + 5'd1 : r_wp;
      r_rp         <= w_done ? 5'd0 : w_fire ? r_rp + 5'd1 : r_rp;
      o_bus_busy   <= w_done ? 1'b0 : w_ok ? 1'b1 : o_bus_busy;
      o_bus_strobe <= w_fire;
      o_error      <= o_error | (w_wr && !w_ok);
      if (w_fire) {o_bus_cmd, o_bus_nibble} <= r_buf[r_rp];
    end
  end
`ifdef SATURN_BUSPROG_READBACK_EN
  logic w_samp;
  logic w_unused;
  assign w_samp   = r_state == READ && i_phases[2] && !i_no_read;
  assign w_unused = ^{i_phases[3], i_phases[0]};
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      o_nibble       <= '0;
      o_nibble_valid <= 1'b0;
    end else begin
      o_nibble_valid <= w_samp;
      if (w_samp) o_nibble <= i_bus_nibble;
    end
  end
`else
  logic w_unused;
  assign w_unused       = ^{i_phases[3], i_phases[2], i_phases[0], i_no_read, i_bus_nibble};
  assign o_nibble       = '0;
  assign o_nibble_valid = 1'b0;
`endif
endmodule

// File: tb/tb_saturn_bus_program_sequencer.sv
// tb_saturn_bus_program_sequencer: directed checks of load, replay, readback, faults and reset.
module tb_saturn_bus_program_sequencer;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] phases;
  logic [4:0] addr, data;
  logic       no_read;
  logic [3:0] bus_in;
  logic       busy, cmd, strobe, valid, err;
  logic [3:0] bus_nib, nib;
  int         errors = 0, checks = 0, nstrobe = 0, n0;
  logic [3:0] exp_nib;
  logic       exp_valid;

  saturn_bus_program_sequencer dut (
    .i_clk(clk), .i_reset(rst), .i_phases(phases), .i_program_address(addr),
    .i_program_data(data), .i_no_read(no_read), .i_bus_nibble(bus_in),
    .o_bus_busy(busy), .o_bus_nibble(bus_nib), .o_bus_cmd(cmd), .o_bus_strobe(strobe),
    .o_nibble(nib), .o_nibble_valid(valid), .o_error(err)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (strobe) nstrobe++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic strobe_cycle(input string tag, input logic ecmd, input logic [3:0] enib);
    phases = 4'b0010;
    step();
    chk({tag, "_strobe"}, 8'(strobe), 8'd1);
    chk({tag, "_cmd"}, 8'(cmd), 8'(ecmd));
    chk({tag, "_nib"}, 8'(bus_nib), 8'(enib));
    phases = 4'b0001;
    step();
    chk({tag, "_gap"}, 8'(strobe), 8'd0);
    chk({tag, "_hold"}, 8'(bus_nib), 8'(enib));
  endtask

  initial begin
    rst = 1'b0; addr = 5'd31; data = '0; phases = '0; no_read = 1'b0; bus_in = '0;
    repeat (3) step();
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_strobe", 8'(strobe), 8'd0);
    chk("rst_busnib", 8'(bus_nib), 8'd0);
    chk("rst_cmd", 8'(cmd), 8'd0);
    chk("rst_nib", 8'(nib), 8'd0);
    chk("rst_valid", 8'(valid), 8'd0);
    chk("rst_err", 8'(err), 8'd0);
    rst = 1'b1;
    // Normal program 0x12 then five zero nibbles
    for (int i = 0; i < 6; i++) begin
      addr = 5'(i); data = (i == 0) ? 5'h12 : 5'h00;
      step();
      chk("load_busy", 8'(busy), 8'd1);
    end
    addr = 5'd31;
    step();
    chk("commit_nostrobe", 8'(strobe), 8'd0);
    strobe_cycle("p0", 1'b1, 4'h2);
    for (int i = 0; i < 5; i++) strobe_cycle("pd", 1'b0, 4'h0);
    chk("busy_fall", 8'(busy), 8'd0);
    chk("strobe_count", 8'(nstrobe), 8'd6);
    chk("no_err", 8'(err), 8'd0);
`ifdef SATURN_BUSPROG_READBACK_EN
    exp_nib = 4'hA; exp_valid = 1'b1;
`else
    exp_nib = 4'h0; exp_valid = 1'b0;
`endif
    phases = 4'b0100; bus_in = 4'hA;
    step();
    chk("rb_valid", 8'(valid), 8'(exp_valid));
    chk("rb_nib", 8'(nib), 8'(exp_nib));
    phases = 4'b0000;
    step();
    chk("rb_valid_pulse", 8'(valid), 8'd0);
    chk("rb_hold", 8'(nib), 8'(exp_nib));
    no_read = 1'b1; phases = 4'b0100; bus_in = 4'h5;
    step();
    chk("noread_valid", 8'(valid), 8'd0);
    chk("noread_nib", 8'(nib), 8'(exp_nib));
    no_read = 1'b0; phases = 4'b0000;
    // Out-of-order write
    addr = 5'd2; data = 5'h1F;
    step();
    chk("ooo_err", 8'(err), 8'd1);
    chk("ooo_busy", 8'(busy), 8'd0);
    addr = 5'd31;
    step();
    // Second program with a write colliding with a phase-1 strobe
    addr = 5'd0; data = 5'h13; step();
    addr = 5'd1; data = 5'h0C; step();
    addr = 5'd31; step();
    phases = 4'b0010; addr = 5'd9; data = 5'h00;
    step();
    chk("coll_strobe", 8'(strobe), 8'd1);
    chk("coll_cmd", 8'(cmd), 8'd1);
    chk("coll_nib", 8'(bus_nib), 8'h3);
    addr = 5'd31; phases = 4'b0001;
    step();
    strobe_cycle("p2", 1'b0, 4'hC);
    chk("p2_busy", 8'(busy), 8'd0);
    chk("err_sticky", 8'(err), 8'd1);
    // Overflow
    rst = 1'b0; step();
    chk("rst2_err", 8'(err), 8'd0);
    rst = 1'b1;
    for (int i = 0; i < 31; i++) begin
      addr = 5'(i); data = 5'(i + 1);
      step();
    end
    chk("full_err", 8'(err), 8'd0);
    chk("full_busy", 8'(busy), 8'd1);
    addr = 5'd0; data = 5'h00;
    step();
    chk("ovf_err", 8'(err), 8'd1);
    step();
    strobe_cycle("ovf0", 1'b0, 4'h1);
    strobe_cycle("ovf1", 1'b0, 4'h2);
    // Reset mid-EXEC
    rst = 1'b0; addr = 5'd31; phases = 4'b0010;
    step();
    chk("mid_busy", 8'(busy), 8'd0);
    chk("mid_strobe", 8'(strobe), 8'd0);
    chk("mid_err", 8'(err), 8'd0);
    chk("mid_nib", 8'(bus_nib), 8'd0);
    phases = 4'b0001; step();
    phases = 4'b0010; step();
    chk("mid_strobe2", 8'(strobe), 8'd0);
    n0 = nstrobe;
    rst = 1'b1;
    step(); step();
    chk("post_strobe", 8'(strobe), 8'd0);
    chk("post_busy", 8'(busy), 8'd0);
    chk("post_count", 8'(nstrobe - n0), 8'd0);
    phases = 4'b0000;
    addr = 5'd0; data = 5'h15;
    step();
    chk("one_busy", 8'(busy), 8'd1);
    addr = 5'd31;
    step();
    strobe_cycle("one", 1'b1, 4'h5);
    chk("one_done", 8'(busy), 8'd0);
    phases = 4'b0010;
    step(); step();
    chk("one_count", 8'(nstrobe - n0), 8'd1);
    chk("one_nostrobe", 8'(strobe), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/saturn_bus_program_sequencer.md
SATURN_BUS_PROGRAM_SEQUENCER -- requirements
Module: saturn_bus_program_sequencer

Interface
REQ-001 The block SHALL have these ports:
- i_clk  in  1  clock.
- i_reset  in  1  reset; synchronous, active-low.
- i_phases  in  4  one-hot bus phase strobes.
- i_program_address  in  5  program slot written by the control unit; 31 = park, no write.
- i_program_data  in  5  bit4 = command flag, bits3:0 = command code or data nibble.
- i_no_read  in  1  suppresses bus readback.
- i_bus_nibble  in  4  nibble returned from the Saturn bus.
- o_bus_busy  out  1  program pending or executing.
- o_bus_nibble  out  4  nibble driven onto the bus.
- o_bus_cmd  out  1  o_bus_nibble is a command.
- o_bus_strobe  out  1  one-cycle qualifier for o_bus_nibble and o_bus_cmd.
- o_nibble  out  4  readback nibble to the control unit.
- o_nibble_valid  out  1  one-cycle qualifier for o_nibble.
- o_error  out  1  sticky protocol error.

Function
REQ-002 Storage SHALL be a 31-entry x 5-bit program buffer (slots 0..30), a 5-bit write pointer wp, a 5-bit read pointer rp, and last_addr, a 5-bit register holding the previous i_program_address.
- Write: a write SHALL occur in any cycle where i_program_address != last_addr and i_program_address != 31.
- Park: address 31 is never stored.
- last_addr update: last_addr SHALL take i_program_address every cycle.
REQ-003 An accepted write SHALL store i_program_data at slot wp, increment wp, and assert o_bus_busy from the next cycle onward.
REQ-004 Write faults: a write SHALL be dropped and o_error set in any of these cases:
- address != wp (out of order);
- wp == 31 (buffer full);
- state is EXEC.
REQ-005 State machine states: IDLE, LOAD, EXEC, READ.
- IDLE to LOAD on the first accepted write.
- LOAD to EXEC on the first cycle with no write after the last accepted write (commit on gap).
- EXEC to READ after rp == wp.
- READ to LOAD on an accepted write.
REQ-006 In EXEC, on each i_phases[1] cycle, the block SHALL:
- drive o_bus_nibble = buf[rp][3:0] and o_bus_cmd = buf[rp][4];
- pulse o_bus_strobe for exactly one cycle;
- increment rp.
This gives a latency of one clock from the phase strobe to the registered outputs.
REQ-007 On the EXEC-to-READ transition the block SHALL:
- clear wp and rp to 0;
- deassert o_bus_busy in the same cycle.
REQ-008 In READ with i_no_read = 0, each i_phases[2] cycle SHALL register o_nibble = i_bus_nibble with a one-cycle o_nibble_valid pulse. With i_no_read = 1, o_nibble_valid SHALL stay 0.
REQ-009 If i_phases[1] and a write coincide in EXEC, the write SHALL be dropped with an error and the bus drive SHALL still proceed.
REQ-010 Outputs SHALL be registered. o_bus_nibble and o_nibble SHALL hold their last value between strobes.
REQ-011 o_error SHALL remain set until reset.

Reset
REQ-012 When i_reset = 0 at a clock edge, the block SHALL take these values:
- state = IDLE; wp = rp = 0; last_addr = 31;
- o_bus_busy = 0, o_bus_nibble = 0, o_bus_cmd = 0, o_bus_strobe = 0;
- o_nibble = 0, o_nibble_valid = 0, o_error = 0.
Buffer contents are unchanged.
REQ-013 Reset SHALL take priority over all other activity, including in the middle of EXEC. There SHALL be no bus strobe in the reset cycle.

Configuration
REQ-014 The readback path SHALL be controlled by macro SATURN_BUSPROG_READBACK_EN.
- Defined: the READ state samples the bus per REQ-008.
- Undefined: READ performs no sampling; o_nibble and o_nibble_valid are tied to 0; all other behaviour is unchanged.

Verification
REQ-015 Normal program: write slots 0..5 = 0x12, 0x00, 0x00, 0x00, 0x00, 0x00 on consecutive cycles, then park.
- Six o_bus_strobe pulses on successive i_phases[1] cycles.
- First pulse: o_bus_cmd = 1, o_bus_nibble = 0x2; then five pulses with o_bus_cmd = 0, o_bus_nibble = 0x0.
- o_bus_busy falls after the sixth pulse.
REQ-016 Readback: after REQ-015, i_bus_nibble = 0xA with i_phases[2] -> o_nibble = 0xA and o_nibble_valid high for one cycle. Repeat with i_no_read = 1 -> no valid pulse.
REQ-017 Out-of-order write: write slot 2 while wp = 0 -> write dropped, o_error = 1, and o_error stays 1 through later valid programs.
REQ-018 Overflow: write slots 0..30 -> accepted. A further write to slot 0 is not possible without a gap, so force wp = 31 with address 30 -> 0 -> error set, no slot 0 overwrite.
REQ-019 Reset mid-EXEC: assert i_reset = 0 after two strobes -> o_bus_busy = 0, no further strobes. A fresh 1-entry program 0x15 then yields a single strobe with o_bus_cmd = 1, o_bus_nibble = 0x5.
REQ-020 Build the bench without SATURN_BUSPROG_READBACK_EN -> o_nibble_valid never asserts; REQ-015 results are unchanged.
